// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage of a 5-stage MIPS pipeline. Holds the
//            PC, drives the instruction-memory address, and captures the
//            returned word into the IF/ID register. Handles stall, redirect
//            (with optional delay slot), flush and fetch-fault detection.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned IM_WORDS   = 1024,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        if_id_fault,
  output logic [31:0] fetch_count
);

  // First byte address past the instruction-memory window (32-bit arithmetic).
  localparam logic [31:0] c_win_end = RESET_PC + 32'(4 * IM_WORDS);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_ipc;
  logic [31:0] r_ipc4;
  logic        r_valid;
  logic        r_fault;
  logic [31:0] r_count;

  logic [31:0] w_pc4;
  logic [31:0] w_pc_next;
  logic        w_fault;
  logic        w_squash;
  logic        w_bubble;
  logic        w_capture;

  assign im_addr     = r_pc;
  assign w_pc4       = r_pc + 32'd4;
  assign if_id_instr = r_instr;
  assign if_id_pc    = r_ipc;
  assign if_id_pc4   = r_ipc4;
  assign if_id_valid = r_valid;
  assign if_id_fault = r_fault;
  assign fetch_count = r_count;

  // Fetch is illegal if misaligned or outside [RESET_PC, c_win_end).
  assign w_fault = (r_pc[1:0] != 2'b00) || (r_pc < RESET_PC) || (r_pc >= c_win_end);

  // Without a delay slot, the instruction behind a taken redirect is dropped.
  // A stalled cycle ignores the redirect, so it cannot squash either.
  assign w_squash  = redirect_valid && (DELAY_SLOT == 1'b0) && !stall;
  assign w_bubble  = flush || w_squash;
  assign w_capture = !flush && !stall && !w_squash;

  // Next-PC select: stall holds, redirect jumps, otherwise sequential.
  always_comb begin
    w_pc_next = w_pc4;
    if (stall) begin
      w_pc_next = r_pc;
    end else if (redirect_valid) begin
      w_pc_next = redirect_pc;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // IF/ID pipeline register: bubble, hold, or capture the current fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= 32'd0;
      r_ipc   <= 32'd0;
      r_ipc4  <= 32'd0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else if (w_bubble) begin
      r_instr <= 32'd0;
      r_ipc   <= 32'd0;
      r_ipc4  <= 32'd0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else if (w_capture) begin
      r_instr <= w_fault ? 32'd0 : im_data;
      r_ipc   <= r_pc;
      r_ipc4  <= w_pc4;
      r_valid <= 1'b1;
      r_fault <= w_fault;
    end
  end

  // Count every instruction loaded into IF/ID as valid, faulting ones included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 32'd0;
    end else if (w_capture) begin
      r_count <= r_count + 32'd1;
    end
  end

endmodule
`default_nettype wire
